// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory port arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory-pin and status signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_wr;
    logic [ADDR_W-1:0] p0_adr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p1_req;
    logic              p1_wr;
    logic [ADDR_W-1:0] p1_adr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_mrd;
    logic              mem_mwr;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    logic              gnt_id;

    modport slave (
        input  p0_req, p0_wr, p0_adr, p0_wdata,
        input  p1_req, p1_wr, p1_adr, p1_wdata,
        input  mem_dout,
        output p0_ack, p1_ack, rdata,
        output mem_adr, mem_din, mem_mrd, mem_mwr,
        output busy, gnt_id
    );

    modport master (
        output p0_req, p0_wr, p0_adr, p0_wdata,
        output p1_req, p1_wr, p1_adr, p1_wdata,
        output mem_dout,
        input  p0_ack, p1_ack, rdata,
        input  mem_adr, mem_din, mem_mrd, mem_mwr,
        input  busy, gnt_id
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Combinational 2-way round-robin pick; a tie goes to the port that did not win last.
module mem_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = req1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between fetch (port 0) and data (port 1); 3+WAIT_CYC cycles per transaction.
// Requests are only sampled in IDLE; memory strobes are decoded from registered state only.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 0
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LD =
        (WAIT_CYC > WAIT_MAX) ? CNT_W'(WAIT_MAX) : CNT_W'(WAIT_CYC);

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt;
    logic              gnt_q;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_adr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              arb_vld;
    logic              arb_id;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;

    mem_rr_arbiter u_rr (
        .req0      (bus.p0_req),
        .req1      (bus.p1_req),
        .last_gnt  (last_gnt),
        .gnt_valid (arb_vld),
        .gnt_id    (arb_id)
    );

    assign sel_wr    = arb_id ? bus.p1_wr    : bus.p0_wr;
    assign sel_adr   = arb_id ? bus.p1_adr   : bus.p0_adr;
    assign sel_wdata = arb_id ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_vld) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt  <= PORT_DM;
            gnt_q     <= PORT_IF;
            cap_wr    <= 1'b0;
            cap_adr   <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            if (state == IDLE && arb_vld) begin
                cap_wr    <= sel_wr;
                cap_adr   <= sel_adr;
                cap_wdata <= sel_wdata;
                gnt_q     <= arb_id;
                last_gnt  <= arb_id;
                cnt       <= WAIT_LD;
            end
            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!cap_wr) begin
                    rdata_q <= bus.mem_dout;
                end
            end
        end
    end

    // A write strobes only in the last ACCESS cycle so the memory sees exactly one write edge.
    assign bus.mem_adr = cap_adr;
    assign bus.mem_din = cap_wdata;
    assign bus.mem_mrd = (state == ACCESS) && !cap_wr;
    assign bus.mem_mwr = (state == ACCESS) && cap_wr && (cnt == '0);
    assign bus.busy    = (state != IDLE);
    assign bus.p0_ack  = (state == RESP) && (gnt_q == PORT_IF);
    assign bus.p1_ack  = (state == RESP) && (gnt_q == PORT_DM);
    assign bus.gnt_id  = gnt_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: rounds of random requests, transaction-level model predicts grant order, timing and data.
module tb_mem_port_arbiter;
    localparam int W = 2;

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ntot = 0;
    int   nerr = 0;
    bit   abort_mode = 1'b0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t        exp_q[$];
    logic        m_last;
    logic [31:0] m_rdata;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_dout = tb_mem[bus.mem_adr[11:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ntot++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic clock_proc();
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (bus.mem_mwr) tb_mem[bus.mem_adr[11:2]] <= bus.mem_din;
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   n_rd = 0;
        int   n_wr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_rd = 0;
                n_wr = 0;
            end else begin
                if (bus.p0_ack && bus.p1_ack) chk("dual_ack", 32'd1, 32'd0);
                if ((bus.mem_mrd || bus.mem_mwr) && !abort_mode) begin
                    if (exp_q.size() == 0) begin
                        chk("strobe_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("mem_adr", bus.mem_adr, e.adr);
                        chk("strobe_kind", {30'd0, bus.mem_mwr, bus.mem_mrd}, e.wr ? 32'd2 : 32'd1);
                        if (bus.mem_mwr) begin
                            n_wr++;
                            chk("mem_din", bus.mem_din, e.wdata);
                            chk("mwr_cycle", cyc, e.ack_cyc - 1);
                        end
                        if (bus.mem_mrd) begin
                            n_rd++;
                            chk("mrd_window", 32'(cyc >= e.ack_cyc - 1 - W && cyc <= e.ack_cyc - 1), 32'd1);
                        end
                    end
                end
                if (bus.p0_ack || bus.p1_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", {31'd0, bus.p1_ack}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", {31'd0, bus.p1_ack}, {31'd0, e.port});
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("rdata", bus.rdata, e.rdata);
                        chk("busy_resp", {31'd0, bus.busy}, 32'd1);
                        chk("gnt_id", {31'd0, bus.gnt_id}, {31'd0, e.port});
                        if (e.wr) chk("write_strobes", n_wr, 1);
                        else      chk("read_strobes", n_rd, W + 1);
                    end
                    n_rd = 0;
                    n_wr = 0;
                end
            end
        end
    endtask

    task automatic do_round(input bit r0, input bit r1, input cmd_t c0, input cmd_t c1, input bit perturb);
        int   c;
        int   t;
        int   pending;
        bit   a0;
        bit   a1;
        int   order[$];
        cmd_t cm;
        exp_t e;
        @(posedge clk); #1;
        c = cyc;
        bus.p0_req = r0;
        bus.p1_req = r1;
        if (r0) begin bus.p0_wr = c0.wr; bus.p0_adr = c0.adr; bus.p0_wdata = c0.wdata; end
        if (r1) begin bus.p1_wr = c1.wr; bus.p1_adr = c1.adr; bus.p1_wdata = c1.wdata; end
        if (r0 && r1) order = (m_last == 1'b0) ? '{1, 0} : '{0, 1};
        else if (r0)  order = '{0};
        else          order = '{1};
        t = c;
        foreach (order[i]) begin
            cm        = (order[i] == 1) ? c1 : c0;
            e.port    = (order[i] == 1);
            e.wr      = cm.wr;
            e.adr     = cm.adr;
            e.wdata   = cm.wdata;
            e.ack_cyc = t + 2 + W;
            if (cm.wr) begin
                ref_mem[cm.adr[11:2]] = cm.wdata;
                e.rdata = m_rdata;
            end else begin
                e.rdata = ref_mem[cm.adr[11:2]];
                m_rdata = e.rdata;
            end
            exp_q.push_back(e);
            m_last = e.port;
            t = t + 3 + W;
        end
        pending = int'(r0) + int'(r1);
        for (int k = 0; k < 80 && pending > 0; k++) begin
            @(negedge clk);
            a0 = bus.p0_ack;
            a1 = bus.p1_ack;
            @(posedge clk); #1;
            if (a0 && bus.p0_req) begin bus.p0_req = 1'b0; pending--; end
            if (a1 && bus.p1_req) begin bus.p1_req = 1'b0; pending--; end
            if (perturb && cyc == c + 1) bus.p0_adr = 32'h20;
        end
        if (pending > 0) chk("round_timeout", pending, 0);
    endtask

    cmd_t rd_cmd;
    cmd_t wr_cmd;
    cmd_t ca;
    cmd_t cb;
    int   sel;

    initial begin
        bus.p0_req = 0; bus.p0_wr = 0; bus.p0_adr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_wr = 0; bus.p1_adr = 0; bus.p1_wdata = 0;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'(i) * 32'h01010101 ^ 32'hA5000000;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
        end
        tb_mem[32'h100 >> 2] = 32'h12345678; ref_mem[32'h100 >> 2] = 32'h12345678;
        m_last  = 1'b1;
        m_rdata = 32'h0;
        fork
            clock_proc();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_acks", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
        chk("rst_strobes", {30'd0, bus.mem_mwr, bus.mem_mrd}, 32'd0);
        chk("rst_mem_adr", bus.mem_adr, 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_gnt_id", {31'd0, bus.gnt_id}, 32'd0);
        rst = 1'b0;

        // Lone port-1 request right after reset is granted at once despite last_gnt=1.
        rd_cmd = '{wr: 1'b0, adr: 32'h44, wdata: 32'h0};
        do_round(1'b0, 1'b1, rd_cmd, rd_cmd, 1'b0);
        rd_cmd = '{wr: 1'b0, adr: 32'h100, wdata: 32'h0};
        do_round(1'b1, 1'b0, rd_cmd, rd_cmd, 1'b0);
        wr_cmd = '{wr: 1'b1, adr: 32'h7D0, wdata: 32'hDEADBEEF};
        do_round(1'b0, 1'b1, wr_cmd, wr_cmd, 1'b0);
        rd_cmd = '{wr: 1'b0, adr: 32'h7D0, wdata: 32'h0};
        do_round(1'b1, 1'b0, rd_cmd, rd_cmd, 1'b0);
        ca = '{wr: 1'b0, adr: 32'h200, wdata: 32'h0};
        cb = '{wr: 1'b0, adr: 32'h304, wdata: 32'h0};
        do_round(1'b1, 1'b1, ca, cb, 1'b0);
        do_round(1'b1, 1'b1, cb, ca, 1'b0);
        rd_cmd = '{wr: 1'b0, adr: 32'h10, wdata: 32'h0};
        do_round(1'b1, 1'b0, rd_cmd, rd_cmd, 1'b1);

        // Reset in the middle of a read: no ack, everything back to reset values.
        abort_mode = 1'b1;
        @(posedge clk); #1;
        bus.p0_req = 1'b1; bus.p0_wr = 1'b0; bus.p0_adr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.p0_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_acks", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
        chk("abort_strobes", {30'd0, bus.mem_mwr, bus.mem_mrd}, 32'd0);
        chk("abort_mem_adr", bus.mem_adr, 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        chk("abort_gnt_id", {31'd0, bus.gnt_id}, 32'd0);
        rst = 1'b0;
        m_last  = 1'b1;
        m_rdata = 32'h0;
        repeat (6) @(posedge clk);
        abort_mode = 1'b0;
        ca = '{wr: 1'b0, adr: 32'h0C, wdata: 32'h0};
        cb = '{wr: 1'b1, adr: 32'h0C, wdata: 32'hCAFEF00D};
        do_round(1'b1, 1'b1, ca, cb, 1'b0);
        do_round(1'b0, 1'b1, ca, ca, 1'b0);

        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            sel = $urandom_range(1, 3);
            ca = '{wr: 1'($urandom), adr: 32'($urandom_range(0, 4095)), wdata: $urandom};
            cb = '{wr: 1'($urandom), adr: 32'($urandom_range(0, 4095)), wdata: $urandom};
            if (n % 10 == 0) cb.adr = ca.adr;
            do_round(sel[0], sel[1], ca, cb, 1'b0);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", ntot, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end
endmodule
